// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: recovers digit values, dots and frame status from a multiplexed active-low seven-segment scan bus
module seven_segment_decoder #(
    parameter int NUM_SEGMENTS  = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int STALE_CYCLES  = 1000000
) (
    input  logic                         clk,
    input  logic                         CPU_RESETN,
    input  logic [NUM_SEGMENTS-1:0]      anode,
    input  logic [7:0]                   cathode,
    output logic [NUM_SEGMENTS-1:0][3:0] encoded,
    output logic [NUM_SEGMENTS-1:0]      digit_point,
    output logic [NUM_SEGMENTS-1:0]      digit_valid,
    output logic                         frame_done,
    output logic                         pattern_err,
    output logic                         stale
);
    localparam int IW = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(STALE_CYCLES + 1);

    typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

    logic [NUM_SEGMENTS-1:0] a_s1, a_s2, a_prev;
    logic [7:0]              c_s1, c_s2, c_prev;
    logic [NUM_SEGMENTS-1:0] sel_mask, prev_mask, mask, new_mask;
    logic [IW-1:0]           idx;
    logic                    sel, illegal, illegal_prev, changed;
    logic [6:0]              seg;
    logic [3:0]              glyph_val;
    logic                    glyph_ok, glyph_blank, decodable;
    state_t                  state, next_state;
    logic [SW-1:0]           cnt, next_cnt, run;
    logic                    cap;
    logic [TW-1:0]           stale_cnt, next_stale_cnt;

    // Two-flop synchronizer plus one history stage for change detection; all-ones means idle/blank
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            a_s1   <= '1;
            a_s2   <= '1;
            a_prev <= '1;
            c_s1   <= '1;
            c_s2   <= '1;
            c_prev <= '1;
        end else begin
            a_s1   <= anode;
            a_s2   <= a_s1;
            a_prev <= a_s2;
            c_s1   <= cathode;
            c_s2   <= c_s1;
            c_prev <= c_s2;
        end
    end

    // Classify the synced anode, find the selected digit and detect any bus change
    always_comb begin
        sel_mask     = ~a_s2;
        prev_mask    = ~a_prev;
        sel          = $onehot(sel_mask);
        illegal      = (sel_mask != '0) && !sel;
        illegal_prev = (prev_mask != '0) && !$onehot(prev_mask);
        changed      = {a_s2, c_s2} != {a_prev, c_prev};
        new_mask     = mask | sel_mask;
        idx          = '0;
        for (int i = 0; i < NUM_SEGMENTS; i++)
            if (sel_mask[i]) idx = IW'(i);
    end

    // Map the active-high segment vector back to a hex value, blank or undecodable
    always_comb begin
        seg         = ~c_s2[6:0];
        glyph_ok    = 1'b1;
        glyph_blank = 1'b0;
        glyph_val   = 4'h0;
        case (seg)
            7'h3F: glyph_val = 4'h0;
            7'h06: glyph_val = 4'h1;
            7'h5B: glyph_val = 4'h2;
            7'h4F: glyph_val = 4'h3;
            7'h66: glyph_val = 4'h4;
            7'h6D: glyph_val = 4'h5;
            7'h7D: glyph_val = 4'h6;
            7'h07: glyph_val = 4'h7;
            7'h7F: glyph_val = 4'h8;
            7'h6F: glyph_val = 4'h9;
            7'h77: glyph_val = 4'hA;
            7'h7C: glyph_val = 4'hB;
            7'h39: glyph_val = 4'hC;
            7'h5E: glyph_val = 4'hD;
            7'h79: glyph_val = 4'hE;
            7'h71: glyph_val = 4'hF;
            7'h00: begin
                glyph_ok    = 1'b0;
                glyph_blank = 1'b1;
            end
            default: glyph_ok = 1'b0;
        endcase
        decodable = glyph_ok | glyph_blank;
    end

    // FSM state and settle counter registers
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state <= WAIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next state: a fresh selection (or a change during a dwell) restarts the stability run
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        run        = SW'(1);
        cap        = 1'b0;
        if (!sel) begin
            next_state = WAIT;
            next_cnt   = '0;
        end else if (state != HOLD || changed) begin
            run        = (state == SETTLE && !changed) ? cnt + SW'(1) : SW'(1);
            cap        = run == SW'(SETTLE_CYCLES);
            next_state = cap ? HOLD : SETTLE;
            next_cnt   = run;
        end
    end

    // Capture outputs, seen-mask bookkeeping and one-cycle event pulses
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            encoded     <= '0;
            digit_point <= '0;
            digit_valid <= '0;
            mask        <= '0;
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            pattern_err <= (illegal && !illegal_prev) || (cap && !decodable);
            frame_done  <= cap && decodable && (&new_mask);
            if (cap && decodable) begin
                encoded[idx]     <= glyph_val;
                digit_valid[idx] <= glyph_ok;
                digit_point[idx] <= ~c_s2[7];
                mask             <= (&new_mask) ? '0 : new_mask;
            end
        end
    end

    // Cycles since the last capture, saturating at the stale threshold
    always_comb
        next_stale_cnt = cap ? '0 : (stale_cnt >= TW'(STALE_CYCLES)) ? stale_cnt : stale_cnt + TW'(1);

    // Stale counter and registered stale level
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else begin
            stale_cnt <= next_stale_cnt;
            stale     <= next_stale_cnt >= TW'(STALE_CYCLES);
        end
    end
endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb_seven_segment_decoder: scoreboard bench for the seven-segment scan decoder
module tb_seven_segment_decoder;
    localparam int N = 4;
    localparam int S = 4;
    localparam int T = 50;

    typedef struct {
        logic [3:0][3:0] enc;
        logic [3:0]      pt;
        logic [3:0]      vl;
        logic            fd;
        logic            pe;
        int              cyc;
    } ev_t;

    logic            clk = 1'b0;
    logic            CPU_RESETN;
    logic [N-1:0]    anode;
    logic [7:0]      cathode;
    logic [N-1:0][3:0] encoded;
    logic [N-1:0]    digit_point;
    logic [N-1:0]    digit_valid;
    logic            frame_done;
    logic            pattern_err;
    logic            stale;

    ev_t             q[$];
    logic [3:0][3:0] exp_enc;
    logic [3:0]      exp_pt, exp_vl, seen;
    int              n_tests = 0;
    int              n_fail = 0;
    int              cyc = 0;
    logic [6:0]      glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seven_segment_decoder #(
        .NUM_SEGMENTS(N),
        .SETTLE_CYCLES(S),
        .STALE_CYCLES(T)
    ) dut (
        .clk(clk),
        .CPU_RESETN(CPU_RESETN),
        .anode(anode),
        .cathode(cathode),
        .encoded(encoded),
        .digit_point(digit_point),
        .digit_valid(digit_valid),
        .frame_done(frame_done),
        .pattern_err(pattern_err),
        .stale(stale)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_capture(input int k, input logic [6:0] seg, input logic dot, input int at);
        ev_t e;
        int v;
        logic [23:0] old;
        v = -1;
        for (int i = 0; i < 16; i++)
            if (glyph[i] == seg) v = i;
        e.fd  = 1'b0;
        e.pe  = 1'b0;
        e.cyc = at;
        if (v < 0 && seg != 7'h00) begin
            e.pe  = 1'b1;
            e.enc = exp_enc;
            e.pt  = exp_pt;
            e.vl  = exp_vl;
            q.push_back(e);
            return;
        end
        old        = {exp_enc, exp_pt, exp_vl};
        exp_enc[k] = (v < 0) ? 4'h0 : 4'(v);
        exp_vl[k]  = v >= 0;
        exp_pt[k]  = dot;
        seen[k]    = 1'b1;
        if (seen == 4'hF) begin
            e.fd = 1'b1;
            seen = 4'h0;
        end
        e.enc = exp_enc;
        e.pt  = exp_pt;
        e.vl  = exp_vl;
        if (e.fd || old != {exp_enc, exp_pt, exp_vl}) q.push_back(e);
    endtask

    task automatic show(input int k, input logic [6:0] seg, input logic dot, input int dwell, input logic cap);
        @(posedge clk);
        #1;
        anode   = ~(4'b0001 << k);
        cathode = {~dot, ~seg};
        if (cap) expect_capture(k, seg, dot, cyc + 2 + S);
        repeat (dwell) @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        anode   = '1;
        cathode = '1;
        repeat (n) @(posedge clk);
    endtask

    // Output monitor: every visible output change or pulse must match the next scoreboard entry
    initial begin
        logic [23:0] last, snap;
        ev_t e;
        last = '0;
        forever begin
            @(negedge clk);
            snap = {encoded, digit_point, digit_valid};
            if (CPU_RESETN !== 1'b1) last = '0;
            else if (frame_done || pattern_err || snap != last) begin
                if (q.size() == 0) check("spurious", {6'b0, frame_done, pattern_err, snap}, {8'b0, last});
                else begin
                    e = q.pop_front();
                    check("encoded", 32'(encoded), 32'(e.enc));
                    check("point", 32'(digit_point), 32'(e.pt));
                    check("valid", 32'(digit_valid), 32'(e.vl));
                    check("frame_done", 32'(frame_done), 32'(e.fd));
                    check("pattern_err", 32'(pattern_err), 32'(e.pe));
                    check("cycle", cyc, e.cyc);
                end
                last = snap;
            end
        end
    end

    initial begin
        CPU_RESETN = 1'b0;
        anode      = '1;
        cathode    = '1;
        exp_enc    = '0;
        exp_pt     = '0;
        exp_vl     = '0;
        seen       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_enc", 32'(encoded), 32'h0);
        check("rst_point", 32'(digit_point), 32'h0);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        check("rst_pe", 32'(pattern_err), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);
        @(posedge clk);
        #1 CPU_RESETN = 1'b1;
        show(0, glyph[1], 1'b0, 19, 1'b1);
        show(0, glyph[3], 1'b0, 10, 1'b1);
        show(1, glyph[10], 1'b1, 10, 1'b1);
        show(2, 7'h00, 1'b0, 10, 1'b1);
        show(3, glyph[15], 1'b0, 10, 1'b1);
        @(negedge clk);
        check("frame_enc", 32'(encoded), 32'hF0A3);
        check("frame_valid", 32'(digit_valid), 32'b1011);
        check("frame_point", 32'(digit_point), 32'b0010);
        idle(10);
        @(posedge clk);
        #1 anode = 4'b1100;
        expect_capture(0, 7'h49, 1'b0, cyc + 3);
        repeat (10) @(posedge clk);
        idle(10);
        show(2, 7'h49, 1'b0, 10, 1'b1);
        idle(10);
        show(0, glyph[5], 1'b0, 11, 1'b1);
        show(0, glyph[6], 1'b0, 11, 1'b1);
        @(negedge clk);
        check("stale_low", 32'(stale), 32'h0);
        for (int i = 0; i < 20; i++) show(i % 4, glyph[8], 1'b0, 2, 1'b0);
        @(negedge clk);
        check("stale_high", 32'(stale), 32'h1);
        show(1, glyph[7], 1'b0, 0, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stale_before_cap", 32'(stale), 32'h1);
        @(negedge clk);
        check("stale_at_cap", 32'(stale), 32'h0);
        repeat (6) @(posedge clk);
        show(0, glyph[4], 1'b0, 10, 1'b1);
        show(1, glyph[9], 1'b0, 10, 1'b1);
        @(posedge clk);
        #3 CPU_RESETN = 1'b0;
        anode   = '1;
        cathode = '1;
        #1;
        check("mid_rst_enc", 32'(encoded), 32'h0);
        check("mid_rst_point", 32'(digit_point), 32'h0);
        check("mid_rst_valid", 32'(digit_valid), 32'h0);
        check("mid_rst_stale", 32'(stale), 32'h0);
        exp_enc = '0;
        exp_pt  = '0;
        exp_vl  = '0;
        seen    = '0;
        repeat (3) @(posedge clk);
        #1 CPU_RESETN = 1'b1;
        show(2, glyph[2], 1'b0, 10, 1'b1);
        show(3, glyph[14], 1'b0, 10, 1'b1);
        show(0, glyph[0], 1'b0, 10, 1'b1);
        show(1, glyph[5], 1'b0, 10, 1'b1);
        idle(20);
        check("pending", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
